mem_wb_pipe: RTL

- Parametrised MEM→WB pipeline stage: N parallel writeback lanes, valid/ready handshake, flush, and an optional 2-entry skid buffer.
- Sits between the memory stage and the register-file write ports.
- Drops writes to r0, resolves same-cycle write-address conflicts between lanes, and keeps a retired-write counter.

---
 rtl/mem_wb_pipe.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline stage with N writeback lanes, valid/ready handshake,
// flush, optional 2-entry skid buffer, r0 and same-cycle conflict filtering, retire counter.
`default_nettype none

module mem_wb_pipe #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [LANES*DATA_W-1:0]   mem_reg_write_data,
  input  logic [LANES*ADDR_W-1:0]   mem_reg_write_addr,
  input  logic [LANES-1:0]          mem_reg_write_en,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [LANES*DATA_W-1:0]   wb_reg_write_data,
  output logic [LANES*ADDR_W-1:0]   wb_reg_write_addr,
  output logic [LANES-1:0]          wb_reg_write_en,
  output logic [CNT_W-1:0]          wb_retire_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } state_t;

  logic [LANES*DATA_W-1:0] held_data;
  logic [LANES*ADDR_W-1:0] held_addr;
  logic [LANES-1:0]        held_en;
  logic                    held_valid;
  logic                    accept;
  logic                    consume;
  logic [LANES-1:0]        eff_en;
  logic [CNT_W-1:0]        retire_add;
  logic [CNT_W-1:0]        retire_cnt;

  assign accept  = mem_valid & mem_ready & ~flush;
  assign consume = held_valid & wb_ready;

  generate
    if (SKID != 0) begin : g_skid
      state_t                  state;
      logic                    ready_q;
      logic [LANES*DATA_W-1:0] main_data, skid_data;
      logic [LANES*ADDR_W-1:0] main_addr, skid_addr;
      logic [LANES-1:0]        main_en, skid_en;

      // ready_q is kept equal to (state != BOTH) so mem_ready is a pure flop output.
      always_ff @(posedge clk) begin
        if (rst) begin
          state     <= EMPTY;
          ready_q   <= 1'b1;
          main_data <= '0;
          main_addr <= '0;
          main_en   <= '0;
          skid_data <= '0;
          skid_addr <= '0;
          skid_en   <= '0;
        end else if (flush) begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end else begin
          case (state)
            EMPTY: begin
              if (accept) begin
                main_data <= mem_reg_write_data;
                main_addr <= mem_reg_write_addr;
                main_en   <= mem_reg_write_en;
                state     <= MAIN;
              end
            end
            MAIN: begin
              if (accept && !consume) begin
                skid_data <= mem_reg_write_data;
                skid_addr <= mem_reg_write_addr;
                skid_en   <= mem_reg_write_en;
                state     <= BOTH;
                ready_q   <= 1'b0;
              end else if (accept && consume) begin
                main_data <= mem_reg_write_data;
                main_addr <= mem_reg_write_addr;
                main_en   <= mem_reg_write_en;
              end else if (consume) begin
                state <= EMPTY;
              end
            end
            BOTH: begin
              if (consume) begin
                main_data <= skid_data;
                main_addr <= skid_addr;
                main_en   <= skid_en;
                state     <= MAIN;
                ready_q   <= 1'b1;
              end
            end
            default: begin
              state   <= EMPTY;
              ready_q <= 1'b1;
            end
          endcase
        end
      end

      assign mem_ready  = ready_q;
      assign held_valid = (state != EMPTY);
      assign held_data  = main_data;
      assign held_addr  = main_addr;
      assign held_en    = main_en;
    end else begin : g_single
      logic                    valid_q;
      logic [LANES*DATA_W-1:0] main_data;
      logic [LANES*ADDR_W-1:0] main_addr;
      logic [LANES-1:0]        main_en;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q   <= 1'b0;
          main_data <= '0;
          main_addr <= '0;
          main_en   <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (accept) begin
          valid_q   <= 1'b1;
          main_data <= mem_reg_write_data;
          main_addr <= mem_reg_write_addr;
          main_en   <= mem_reg_write_en;
        end else if (consume) begin
          valid_q <= 1'b0;
        end
      end

      assign mem_ready  = ~valid_q | wb_ready;
      assign held_valid = valid_q;
      assign held_data  = main_data;
      assign held_addr  = main_addr;
      assign held_en    = main_en;
    end
  endgenerate

  // A lane loses to any later lane writing the same register (later = younger in program order).
  always_comb begin
    eff_en     = '0;
    retire_add = '0;
    for (int i = 0; i < LANES; i++) begin
      logic conflict;
      conflict = 1'b0;
      for (int j = i + 1; j < LANES; j++) begin
        if (held_en[j] && (held_addr[j*ADDR_W +: ADDR_W] == held_addr[i*ADDR_W +: ADDR_W]))
          conflict = 1'b1;
      end
      eff_en[i] = held_valid & held_en[i] &
                  (held_addr[i*ADDR_W +: ADDR_W] != '0) & ~conflict;
      retire_add = retire_add + CNT_W'(eff_en[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      retire_cnt <= '0;
    else if (consume && !flush)
      retire_cnt <= retire_cnt + retire_add;
  end

  assign wb_valid          = held_valid;
  assign wb_reg_write_data = held_data;
  assign wb_reg_write_addr = held_addr;
  assign wb_reg_write_en   = eff_en;
  assign wb_retire_cnt     = retire_cnt;

endmodule

`default_nettype wire
